// File: rtl/seg_frame_scan.sv
// seg_frame_scan: tear-free multiplexed NDIG-digit 7-segment scanner with inter-digit blanking
module seg_frame_scan #(
   parameter int DIV   = 50000,
   parameter int BLANK = 1000,
   parameter int NDIG  = 8
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] data_in,
   input  logic        load,
   input  logic [7:0]  en,
   output logic [6:0]  seg,
   output logic [7:0]  sel,
   output logic        busy,
   output logic        frame_end
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] BLK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [2:0] IDX_LAST = 3'(NDIG - 1);
   // segment patterns {g,f,e,d,c,b,a}, active-low; nibble 0 in the lowest 7 bits
   localparam logic [111:0] DEC = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                   7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

   typedef enum logic {S_BLANK, S_SHOW} state_t;
   // with no blanking the scan lives in S_SHOW from reset onwards
   localparam state_t S_RST = (BLANK > 0) ? S_BLANK : S_SHOW;

   state_t         state_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [31:0]    disp_q, disp_d, pend_q, pend_d;
   logic           busy_q, busy_d;
   logic [6:0]     seg_q;
   logic [7:0]     sel_q;
   logic           cnt_last, show;
   logic [3:0]     nib;

   // slot/digit counters, frame boundary and the shadow-register handshake
   always_comb begin
      cnt_last  = cnt_q == CNT_LAST;
      cnt_d     = cnt_last ? '0 : cnt_q + 1'b1;
      idx_d     = cnt_last ? ((idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1) : idx_q;
      frame_end = cnt_last && (idx_q == IDX_LAST);
      disp_d    = (load && frame_end) ? data_in : ((frame_end && busy_q) ? pend_q : disp_q);
      pend_d    = load ? data_in : pend_q;
      busy_d    = frame_end ? 1'b0 : (load | busy_q);
      nib       = disp_q[{idx_q, 2'b00} +: 4];
      show      = (state_q == S_SHOW) && en[idx_q];
   end

   // counter and data registers
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         disp_q <= '0;
         pend_q <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         disp_q <= disp_d;
         pend_q <= pend_d;
         busy_q <= busy_d;
      end
   end

   // blank/show FSM with registered segment and anode drivers taken from the pre-edge state
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_RST;
         seg_q   <= 7'h7F;
         sel_q   <= 8'hFF;
      end else begin
         if (state_q == S_BLANK && cnt_q == BLK_LAST)
            state_q <= S_SHOW;
         else if (state_q == S_SHOW && cnt_last && BLANK > 0)
            state_q <= S_BLANK;
         seg_q <= show ? DEC[nib * 7 +: 7] : 7'h7F;
         sel_q <= show ? ~(8'b1 << idx_q) : 8'hFF;
      end
   end

   assign seg  = seg_q;
   assign sel  = sel_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_seg_frame_scan.sv
// tb_seg_frame_scan: randomized scenarios checked against a cycle-time reference model
module tb_seg_frame_scan;
   localparam int DIV = 8, BLANK = 2, NDIG = 4, FR = DIV * NDIG;

   logic        clk = 1'b0;
   logic        clr = 1'b0, load = 1'b0;
   logic [31:0] data_in = '0;
   logic [7:0]  en = 8'h0F;
   logic [6:0]  seg;
   logic [7:0]  sel;
   logic        busy, frame_end;

   int errs = 0, checks = 0;

   int          t = 0;
   logic [31:0] m_disp = '0, m_pend = '0;
   logic        m_busy = 1'b0;
   logic [6:0]  e_seg = 7'h7F;
   logic [7:0]  e_sel = 8'hFF;
   logic [6:0]  dec_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_frame_scan #(.DIV(DIV), .BLANK(BLANK), .NDIG(NDIG)) dut (
      .clk(clk), .clr(clr), .data_in(data_in), .load(load), .en(en),
      .seg(seg), .sel(sel), .busy(busy), .frame_end(frame_end)
   );

   always #5 clk = ~clk;

   function automatic bit m_fe();
      return (t % FR) == FR - 1;
   endfunction

   // advance the model by one clock from cycle-position arithmetic, then cross the DUT edge
   task automatic tick();
      int  off, slot;
      bit  fe;
      off  = t % DIV;
      slot = (t / DIV) % NDIG;
      fe   = m_fe();
      if (off < BLANK || !en[slot]) begin
         e_seg = 7'h7F;
         e_sel = 8'hFF;
      end else begin
         e_seg = dec_t[m_disp[slot * 4 +: 4]];
         e_sel = ~(8'b1 << slot);
      end
      if (clr) begin
         m_disp = '0; m_pend = '0; m_busy = 1'b0; t = 0;
         e_seg = 7'h7F; e_sel = 8'hFF;
      end else begin
         if (load && fe) begin
            m_disp = data_in; m_busy = 1'b0;
         end else if (fe && m_busy) begin
            m_disp = m_pend; m_busy = 1'b0;
         end
         if (load && !fe) begin
            m_pend = data_in; m_busy = 1'b1;
         end
         t++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b1; load = 1'b1;
      repeat (3) begin
         data_in = $urandom;
         tick();
         checks++;
         if ({seg, sel, busy, frame_end} !== {7'h7F, 8'hFF, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset: seg=%h sel=%h busy=%b fe=%b, want 7f ff 0 0", seg, sel, busy, frame_end);
         end
      end
      clr = 1'b0; load = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL reset_nocapture: busy=%b want 0", busy);
      end
   endtask

   task automatic test_scan();
      for (int i = 0; i < FR && !m_fe(); i++) tick();
      data_in = 32'h0000_3210; load = 1'b1; en = 8'h0F;
      tick();
      load = 1'b0;
      repeat (2 * FR) begin
         tick();
         checks++;
         if ({seg, sel, busy, frame_end} !== {e_seg, e_sel, m_busy, m_fe()}) begin
            errs++;
            $display("FAIL scan t=%0d: seg=%h sel=%h busy=%b fe=%b want %h %h %b %b",
                     t, seg, sel, busy, frame_end, e_seg, e_sel, m_busy, m_fe());
         end
      end
   endtask

   task automatic test_pending();
      for (int i = 0; i < FR && (t % FR) != DIV; i++) tick();
      data_in = 32'h0000_ABCD; load = 1'b1;
      tick();
      load = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errs++;
         $display("FAIL pending_busy: busy=%b want 1", busy);
      end
      repeat (2 * FR) begin
         tick();
         checks++;
         if ({seg, sel, busy, frame_end} !== {e_seg, e_sel, m_busy, m_fe()}) begin
            errs++;
            $display("FAIL pending t=%0d: seg=%h sel=%h busy=%b fe=%b want %h %h %b %b",
                     t, seg, sel, busy, frame_end, e_seg, e_sel, m_busy, m_fe());
         end
      end
   endtask

   task automatic test_load_on_frame_end();
      for (int i = 0; i < FR && !m_fe(); i++) tick();
      checks++;
      if (frame_end !== 1'b1) begin
         errs++;
         $display("FAIL fe_pulse: frame_end=%b want 1", frame_end);
      end
      data_in = 32'h0000_5555; load = 1'b1;
      tick();
      load = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL fe_load_busy: busy=%b want 0", busy);
      end
      repeat (FR + 1) begin
         tick();
         checks++;
         if ({seg, sel, busy, frame_end} !== {e_seg, e_sel, m_busy, m_fe()}) begin
            errs++;
            $display("FAIL fe_load t=%0d: seg=%h sel=%h busy=%b fe=%b want %h %h %b %b",
                     t, seg, sel, busy, frame_end, e_seg, e_sel, m_busy, m_fe());
         end
      end
   endtask

   task automatic test_enable();
      en = 8'b0000_0101;
      repeat (FR + 2) begin
         tick();
         checks++;
         if ({seg, sel, busy, frame_end} !== {e_seg, e_sel, m_busy, m_fe()}) begin
            errs++;
            $display("FAIL enable t=%0d: seg=%h sel=%h busy=%b fe=%b want %h %h %b %b",
                     t, seg, sel, busy, frame_end, e_seg, e_sel, m_busy, m_fe());
         end
      end
      en = 8'h0F;
   endtask

   task automatic test_clr_mid();
      for (int i = 0; i < FR && (t % FR) != 0; i++) tick();
      data_in = $urandom | 32'h1; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < FR && (t % FR) != 2 * DIV + 5; i++) tick();
      checks++;
      if (busy !== 1'b1) begin
         errs++;
         $display("FAIL clr_pre_busy: busy=%b want 1", busy);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if ({seg, sel, busy} !== {7'h7F, 8'hFF, 1'b0}) begin
         errs++;
         $display("FAIL clr_mid: seg=%h sel=%h busy=%b want 7f ff 0", seg, sel, busy);
      end
      repeat (FR) begin
         tick();
         checks++;
         if ({seg, sel, busy, frame_end} !== {e_seg, e_sel, m_busy, m_fe()}) begin
            errs++;
            $display("FAIL clr_resume t=%0d: seg=%h sel=%h busy=%b fe=%b want %h %h %b %b",
                     t, seg, sel, busy, frame_end, e_seg, e_sel, m_busy, m_fe());
         end
      end
   endtask

   task automatic test_random();
      repeat (500) begin
         load    = ($urandom_range(0, 9) == 0);
         data_in = $urandom;
         if ($urandom_range(0, 19) == 0) en = 8'($urandom);
         clr     = ($urandom_range(0, 199) == 0);
         tick();
         checks++;
         if ({seg, sel, busy, frame_end} !== {e_seg, e_sel, m_busy, m_fe()}) begin
            errs++;
            $display("FAIL random t=%0d: seg=%h sel=%h busy=%b fe=%b want %h %h %b %b",
                     t, seg, sel, busy, frame_end, e_seg, e_sel, m_busy, m_fe());
         end
      end
      clr = 1'b0; load = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_scan();
      test_pending();
      test_load_on_frame_end();
      test_enable();
      test_clr_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
